ahb_split_ctrl: RTL and testbench
=================================

# ahb_split_ctrl

Slave-side split controller placed in front of a slow shared AHB resource (e.g. a flash or external-memory bridge). It decides for every selected transfer whether to complete it, insert wait states, or answer SPLIT. It records split masters in a 16-bit pending mask and, once the resource frees, releases them one at a time through HSPLIT to the bus arbiter in round-robin order. Each released master gets a reservation window in which the resource is held for it.

## Interface
- RESV_TIMEOUT, 16: cycles a released master's reservation is held before it lapses (range 1..255).

- HCLK  in  1  bus clock; all state on rising edge
- HRST_N  in  1  asynchronous, active-low reset
- HSEL  in  1  slave select (address phase)
- HTRANS  in  2  transfer type: IDLE 00, BUSY 01, NONSEQ 10, SEQ 11
- HREADY  in  1  bus-level HREADY
- HMASTER  in  4  current address-phase master number
- HMASTLOCK  in  1  locked-sequence indicator
- ResBusy  in  1  resource cannot accept a new transfer
- HREADYOUT  out  1  slave ready
- HRESP  out  2  OKAY 00 / SPLIT 11 only
- HSPLIT  out  16  one-hot split-release pulse to arbiter
- ResStart  out  1  one-cycle pulse: transfer handed to resource
- SplitPend  out  16  pending-split mask (status)

## Operation
- Transfer accepted when HSEL & HREADY & HTRANS[1] = 1. IDLE/BUSY, or no select: zero-wait OKAY, no state change.
- Decision on an accepted transfer from master m:
  - Split if (~HMASTLOCK & ResBusy), or if Reserved & m ≠ ResvMaster & ~HMASTLOCK. Also split if SplitPend[m] is already set.
  - Locked wait if HMASTLOCK & ResBusy.
  - Otherwise OKAY.
- Data-phase FSM:
  - IDLE: HREADYOUT=1, HRESP=OKAY.
  - SPLIT1: HREADYOUT=0, HRESP=SPLIT; SplitPend[m] set on entry edge. Next state is SPLIT2.
  - SPLIT2: HREADYOUT=1, HRESP=SPLIT. Next state is IDLE, or a new decision if a transfer is accepted this cycle.
  - LWAIT: HREADYOUT=0, HRESP=OKAY while ResBusy. When ResBusy=0, go to IDLE-style completion with HREADYOUT=1 and pulse ResStart.
- OKAY: ResStart pulses for one cycle in the first data-phase cycle. If m = ResvMaster, Reserved clears on the same edge.
- Locked transfers are never split. A locked transfer ignores any reservation and does not clear it.
- Release: eligible when ~ResBusy & |SplitPend & ~Reserved, no split decision in the current cycle, and FSM not in SPLIT1.
  - Selected master r = first set bit of SplitPend, searching upward from (LastRel+1) mod 16 and wrapping at 15→0.
  - On the edge: HSPLIT[r]=1 for exactly one cycle, SplitPend[r] cleared, LastRel←r, Reserved←1, ResvMaster←r, ResvCnt←RESV_TIMEOUT.
- Reservation:
  - ResvCnt decrements each cycle while Reserved.
  - Reserved clears when ResvCnt reaches 1 and decrements, or when an OKAY access by ResvMaster occurs.
  - A lapsed master is not re-pended; a later access is treated normally.
- Simultaneous events:
  - A split decision and release eligibility in the same cycle: the split wins and the release is deferred one cycle.
  - A set and a clear of the same SplitPend bit on one edge cannot occur.
- Reset mid-operation: all state returns to reset values immediately. Pending masters are lost; the arbiter side is reset by the same HRST_N.

## Timing
- Reset values: HREADYOUT=1, HRESP=00, HSPLIT=0, ResStart=0, SplitPend=0, Reserved=0, ResvCnt=0, LastRel=15 (so the first search starts at master 0), FSM=IDLE.
- All outputs are registered.
- SPLIT response is exactly 2 cycles. OKAY latency is 0 wait states unless locked-waiting.
- First HSPLIT pulse occurs no earlier than 1 cycle after ResBusy falls. At most one HSPLIT bit is high per cycle.
- Minimum spacing between releases is 2 cycles (reservation cleared plus eligibility re-evaluated).
- SplitPend is updated on the same edge as the SPLIT1 entry or the HSPLIT assertion.

## Test plan
- Reset: assert HRST_N=0 mid-SPLIT1 → next cycle all outputs at reset values, SplitPend=0x0000.
- Non-locked access, master 3, ResBusy=1 → HRESP=11 for 2 cycles, HREADYOUT 0 then 1, SplitPend=0x0008. Drop ResBusy → HSPLIT=0x0008 for one cycle, SplitPend=0x0000.
- Round-robin: masters 2, 5 and 9 pending, LastRel=5, ResBusy=0 → HSPLIT releases 0x0200 first. After each reservation clears, releases 0x0004, then 0x0020.
- Reservation: after releasing master 9, master 1 accesses with ResBusy=0 → split, SplitPend=0x0002. Master 9 then accesses → OKAY, ResStart=1 for one cycle, Reserved clears, next HSPLIT=0x0002.
- Timeout: RESV_TIMEOUT=4, released master never returns, another master pending → Reserved clears 4 cycles after HSPLIT, next HSPLIT appears 1 cycle later.
- Locked: HMASTLOCK=1, master 6, ResBusy high for 3 cycles → 3 cycles HREADYOUT=0 with HRESP=00, then HREADYOUT=1 with ResStart=1, SplitPend unchanged.

Source files
------------

// File: rtl/ahb_split_ctrl.sv
// ahb_split_ctrl
// Slave-side split controller for a slow shared AHB resource. For every
// accepted transfer it chooses one of three responses: complete it (OKAY),
// hold it with wait states (locked transfers only), or answer SPLIT. Split
// masters are collected in a pending mask. When the resource is free, they are
// released one at a time through HSPLIT in round-robin order. Each released
// master gets a reservation window of RESV_TIMEOUT cycles.
//
// Ports:
//   HCLK, HRST_N  clock; asynchronous active-low reset
//   HSEL, HTRANS, HREADY, HMASTER, HMASTLOCK  address-phase inputs
//   ResBusy       resource cannot accept a new transfer
//   HREADYOUT     slave ready (registered)
//   HRESP         OKAY 2'b00 / SPLIT 2'b11 (registered)
//   HSPLIT        one-hot split-release pulse to the arbiter (registered)
//   ResStart      one-cycle pulse when a transfer is handed to the resource
//   SplitPend     pending-split mask (status)
module ahb_split_ctrl #(
  parameter int unsigned RESV_TIMEOUT = 16
) (
  input  logic        HCLK,
  input  logic        HRST_N,
  input  logic        HSEL,
  input  logic [1:0]  HTRANS,
  input  logic        HREADY,
  input  logic [3:0]  HMASTER,
  input  logic        HMASTLOCK,
  input  logic        ResBusy,
  output logic        HREADYOUT,
  output logic [1:0]  HRESP,
  output logic [15:0] HSPLIT,
  output logic        ResStart,
  output logic [15:0] SplitPend
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SPLIT1 = 2'd1,
    ST_SPLIT2 = 2'd2,
    ST_LWAIT  = 2'd3
  } state_t;

  localparam logic [7:0] RESV_LOAD = 8'(RESV_TIMEOUT);

  state_t      state_q, state_d;
  logic        reserved_q, reserved_d;
  logic [3:0]  resv_master_q, resv_master_d;
  logic [7:0]  resv_cnt_q, resv_cnt_d;
  logic [3:0]  last_rel_q, last_rel_d;
  logic [15:0] split_pend_d, hsplit_d;
  logic        hreadyout_d, res_start_d;
  logic [1:0]  hresp_d;
  logic        accept, do_split, do_lwait, do_okay, do_release;
  logic        rel_found;
  logic [3:0]  rel_idx, cand;

  // A new address phase is taken only while no data phase of ours is
  // stalling. In SPLIT1 and LWAIT, HREADY is low anyway.
  // The round-robin search starts one past the last released master.
  always_comb begin
    accept   = HSEL && HREADY && (HTRANS inside {2'b10, 2'b11}) &&
               (state_q == ST_IDLE || state_q == ST_SPLIT2);
    do_split = accept && !HMASTLOCK &&
               (ResBusy || (reserved_q && HMASTER != resv_master_q) || SplitPend[HMASTER]);
    do_lwait = accept && HMASTLOCK && ResBusy;
    do_okay  = accept && !do_split && !do_lwait;

    rel_found = 1'b0;
    rel_idx   = 4'd0;
    cand      = 4'd0;
    for (int i = 0; i < 16; i++) begin
      cand = last_rel_q + 4'(i + 1);
      if (!rel_found && SplitPend[cand]) begin
        rel_found = 1'b1;
        rel_idx   = cand;
      end
    end

    // A split decision in this cycle defers the release by one cycle.
    do_release = rel_found && !ResBusy && !reserved_q && !do_split &&
                 (state_q != ST_SPLIT1);
  end

  // Next-state, reservation and output logic. Outputs are computed from the
  // next state, so every output is a flop.
  always_comb begin
    state_d       = state_q;
    reserved_d    = reserved_q;
    resv_master_d = resv_master_q;
    resv_cnt_d    = resv_cnt_q;
    last_rel_d    = last_rel_q;
    split_pend_d  = SplitPend;
    hsplit_d      = 16'h0000;
    res_start_d   = 1'b0;

    case (state_q)
      ST_IDLE, ST_SPLIT2: begin
        if (do_split)      state_d = ST_SPLIT1;
        else if (do_lwait) state_d = ST_LWAIT;
        else               state_d = ST_IDLE;
      end
      ST_SPLIT1: state_d = ST_SPLIT2;
      ST_LWAIT: begin
        if (!ResBusy) begin
          state_d     = ST_IDLE;
          res_start_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (do_okay) res_start_d = 1'b1;

    if (do_split) split_pend_d[HMASTER] = 1'b1;

    // A locked OKAY by the reserved master neither uses nor ends the
    // reservation. Only an unlocked OKAY ends it early.
    if (reserved_q) begin
      if (do_okay && !HMASTLOCK && HMASTER == resv_master_q) begin
        reserved_d = 1'b0;
        resv_cnt_d = 8'd0;
      end else if (resv_cnt_q <= 8'd1) begin
        reserved_d = 1'b0;
        resv_cnt_d = 8'd0;
      end else begin
        resv_cnt_d = resv_cnt_q - 8'd1;
      end
    end else if (do_release) begin
      hsplit_d[rel_idx]     = 1'b1;
      split_pend_d[rel_idx] = 1'b0;
      last_rel_d            = rel_idx;
      reserved_d            = 1'b1;
      resv_master_d         = rel_idx;
      resv_cnt_d            = RESV_LOAD;
    end

    hreadyout_d = !(state_d == ST_SPLIT1 || state_d == ST_LWAIT);
    hresp_d     = (state_d == ST_SPLIT1 || state_d == ST_SPLIT2) ? 2'b11 : 2'b00;
  end

  always_ff @(posedge HCLK or negedge HRST_N) begin
    if (!HRST_N) begin
      state_q       <= ST_IDLE;
      reserved_q    <= 1'b0;
      resv_master_q <= 4'd0;
      resv_cnt_q    <= 8'd0;
      last_rel_q    <= 4'hF;
      HREADYOUT     <= 1'b1;
      HRESP         <= 2'b00;
      HSPLIT        <= 16'h0000;
      ResStart      <= 1'b0;
      SplitPend     <= 16'h0000;
    end else begin
      state_q       <= state_d;
      reserved_q    <= reserved_d;
      resv_master_q <= resv_master_d;
      resv_cnt_q    <= resv_cnt_d;
      last_rel_q    <= last_rel_d;
      HREADYOUT     <= hreadyout_d;
      HRESP         <= hresp_d;
      HSPLIT        <= hsplit_d;
      ResStart      <= res_start_d;
      SplitPend     <= split_pend_d;
    end
  end

endmodule

// File: tb/tb_ahb_split_ctrl.sv
// tb_ahb_split_ctrl
// Self-checking bench for ahb_split_ctrl. A behavioural model predicts the
// outputs after every clock edge and queues them. A monitor process pops one
// entry per edge and compares it with the DUT. Directed sequences for reset,
// split/release, round-robin, reservation, timeout and locked waits are run
// first. A randomized phase follows.
module tb_ahb_split_ctrl;

  localparam int TB_TIMEOUT = 4;

  logic        HCLK;
  logic        HRST_N;
  logic        HSEL;
  logic [1:0]  HTRANS;
  logic        HREADY;
  logic [3:0]  HMASTER;
  logic        HMASTLOCK;
  logic        ResBusy;
  logic        HREADYOUT;
  logic [1:0]  HRESP;
  logic [15:0] HSPLIT;
  logic        ResStart;
  logic [15:0] SplitPend;
  logic        other_ready;

  int checks = 0;
  int errors = 0;
  int cycle_cnt = 0;
  bit monitor_on = 0;

  // Bus HREADY combines our own ready with stalls from other slaves.
  assign HREADY = HREADYOUT & other_ready;

  ahb_split_ctrl #(.RESV_TIMEOUT(TB_TIMEOUT)) dut (
    .HCLK      (HCLK),
    .HRST_N    (HRST_N),
    .HSEL      (HSEL),
    .HTRANS    (HTRANS),
    .HREADY    (HREADY),
    .HMASTER   (HMASTER),
    .HMASTLOCK (HMASTLOCK),
    .ResBusy   (ResBusy),
    .HREADYOUT (HREADYOUT),
    .HRESP     (HRESP),
    .HSPLIT    (HSPLIT),
    .ResStart  (ResStart),
    .SplitPend (SplitPend)
  );

  initial begin
    HCLK = 1'b0;
    forever #5 HCLK = ~HCLK;
  end

  always @(posedge HCLK) cycle_cnt <= cycle_cnt + 1;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // ---------------- reference model ----------------
  typedef enum {MS_IDLE, MS_SPLIT_A, MS_SPLIT_B, MS_LOCKED} mstage_t;

  typedef struct {
    bit        rdy;
    bit [1:0]  resp;
    bit [15:0] split;
    bit        start;
    bit [15:0] pend;
  } exp_t;

  exp_t      exp_q[$];
  exp_t      mon_e;
  bit [15:0] m_pend;
  int        m_last;
  bit        m_resv;
  int        m_who;
  int        m_left;
  mstage_t   m_stage;
  bit        cur_rdy;

  task automatic modelReset();
    m_pend  = 16'h0;
    m_last  = 15;
    m_resv  = 1'b0;
    m_who   = 0;
    m_left  = 0;
    m_stage = MS_IDLE;
    cur_rdy = 1'b1;
  endtask

  task automatic modelStep(input bit sel, input bit [1:0] trans, input bit [3:0] mst,
                           input bit lock, input bit busy, input bit oready);
    bit   acc, split, lwait, okay, finish_lock;
    int   rel;
    exp_t e;
    acc         = sel && cur_rdy && oready && trans[1];
    split       = acc && !lock && (busy || (m_resv && int'(mst) != m_who) || m_pend[mst]);
    lwait       = acc && lock && busy;
    okay        = acc && !split && !lwait;
    finish_lock = (m_stage == MS_LOCKED) && !busy;

    rel = -1;
    if (!busy && m_pend != 16'h0 && !m_resv && !split && m_stage != MS_SPLIT_A) begin
      for (int k = 1; k <= 16; k++) begin
        int idx;
        idx = (m_last + k) % 16;
        if (rel < 0 && m_pend[idx]) rel = idx;
      end
    end

    if (m_resv) begin
      if (okay && !lock && int'(mst) == m_who) begin
        m_resv = 1'b0;
      end else begin
        m_left--;
        if (m_left == 0) m_resv = 1'b0;
      end
    end else if (rel >= 0) begin
      m_resv = 1'b1;
      m_who  = rel;
      m_left = TB_TIMEOUT;
      m_last = rel;
    end

    if (split) m_pend[mst] = 1'b1;
    if (rel >= 0) m_pend[rel] = 1'b0;

    if (split)                                m_stage = MS_SPLIT_A;
    else if (lwait)                           m_stage = MS_LOCKED;
    else if (m_stage == MS_SPLIT_A)           m_stage = MS_SPLIT_B;
    else if (m_stage == MS_LOCKED && busy)    m_stage = MS_LOCKED;
    else                                      m_stage = MS_IDLE;

    e.rdy   = !(m_stage == MS_SPLIT_A || m_stage == MS_LOCKED);
    e.resp  = (m_stage == MS_SPLIT_A || m_stage == MS_SPLIT_B) ? 2'b11 : 2'b00;
    e.split = (rel >= 0) ? (16'h1 << rel) : 16'h0;
    e.start = okay || finish_lock;
    e.pend  = m_pend;
    cur_rdy = e.rdy;
    exp_q.push_back(e);
  endtask

  // ---------------- checking ----------------
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
               name, actual, expected, cycle_cnt);
    end
  endtask

  initial begin
    forever begin
      @(posedge HCLK);
      #1;
      if (monitor_on && exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        checkOutput("sb_HREADYOUT", 32'(HREADYOUT), 32'(mon_e.rdy));
        checkOutput("sb_HRESP",     32'(HRESP),     32'(mon_e.resp));
        checkOutput("sb_HSPLIT",    32'(HSPLIT),    32'(mon_e.split));
        checkOutput("sb_ResStart",  32'(ResStart),  32'(mon_e.start));
        checkOutput("sb_SplitPend", 32'(SplitPend), 32'(mon_e.pend));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic applyStimulus(input bit sel, input bit [1:0] trans, input bit [3:0] mst,
                               input bit lock, input bit busy, input bit oready);
    @(negedge HCLK);
    HSEL        = sel;
    HTRANS      = trans;
    HMASTER     = mst;
    HMASTLOCK   = lock;
    ResBusy     = busy;
    other_ready = oready;
    modelStep(sel, trans, mst, lock, busy, oready);
  endtask

  task automatic stepIdle(input bit busy);
    applyStimulus(1'b0, 2'b00, 4'd0, 1'b0, busy, 1'b1);
  endtask

  task automatic access(input bit [3:0] mst, input bit lock, input bit busy);
    applyStimulus(1'b1, 2'b10, mst, lock, busy, 1'b1);
  endtask

  task automatic sampleAfterEdge();
    @(posedge HCLK);
    #2;
  endtask

  task automatic waitRelease(input string name, input logic [15:0] expected, output int waited);
    waited = 0;
    do begin
      stepIdle(1'b0);
      sampleAfterEdge();
      waited++;
    end while (HSPLIT == 16'h0 && waited < 20);
    checkOutput(name, 32'(HSPLIT), 32'(expected));
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_HREADYOUT"}, 32'(HREADYOUT), 32'd1);
    checkOutput({tag, "_HRESP"},     32'(HRESP),     32'd0);
    checkOutput({tag, "_HSPLIT"},    32'(HSPLIT),    32'd0);
    checkOutput({tag, "_ResStart"},  32'(ResStart),  32'd0);
    checkOutput({tag, "_SplitPend"}, 32'(SplitPend), 32'd0);
  endtask

  initial begin
    int  w;
    bit  busy_r;
    HRST_N      = 1'b0;
    HSEL        = 1'b0;
    HTRANS      = 2'b00;
    HMASTER     = 4'd0;
    HMASTLOCK   = 1'b0;
    ResBusy     = 1'b0;
    other_ready = 1'b1;
    modelReset();
    repeat (3) @(posedge HCLK);
    #2;
    checkResetOutputs("reset");
    @(negedge HCLK);
    HRST_N     = 1'b1;
    monitor_on = 1'b1;

    // Master 3 split while busy, then released when the resource frees
    access(4'd3, 1'b0, 1'b1);
    sampleAfterEdge();
    checkOutput("m3_resp_first",  32'(HRESP),     32'd3);
    checkOutput("m3_ready_first", 32'(HREADYOUT), 32'd0);
    checkOutput("m3_pend",        32'(SplitPend), 32'h0008);
    stepIdle(1'b1);
    sampleAfterEdge();
    checkOutput("m3_resp_second",  32'(HRESP),     32'd3);
    checkOutput("m3_ready_second", 32'(HREADYOUT), 32'd1);
    waitRelease("m3_release", 16'h0008, w);
    checkOutput("m3_pend_cleared", 32'(SplitPend), 32'h0000);
    repeat (6) stepIdle(1'b0);

    // Make master 5 the last released master
    access(4'd5, 1'b0, 1'b1);
    stepIdle(1'b1);
    waitRelease("m5_release", 16'h0020, w);
    repeat (6) stepIdle(1'b0);

    // Round-robin with 2, 5, 9 pending and a reservation conflict
    access(4'd2, 1'b0, 1'b1);
    stepIdle(1'b1);
    access(4'd5, 1'b0, 1'b1);
    stepIdle(1'b1);
    access(4'd9, 1'b0, 1'b1);
    stepIdle(1'b1);
    sampleAfterEdge();
    checkOutput("rr_pend", 32'(SplitPend), 32'h0224);
    waitRelease("rr_first", 16'h0200, w);
    access(4'd1, 1'b0, 1'b0);
    sampleAfterEdge();
    checkOutput("resv_split_resp", 32'(HRESP),     32'd3);
    checkOutput("resv_split_pend", 32'(SplitPend), 32'h0026);
    stepIdle(1'b0);
    access(4'd9, 1'b0, 1'b0);
    sampleAfterEdge();
    checkOutput("resv_okay_start", 32'(ResStart),  32'd1);
    checkOutput("resv_okay_resp",  32'(HRESP),     32'd0);
    checkOutput("resv_okay_ready", 32'(HREADYOUT), 32'd1);
    waitRelease("rr_after_okay", 16'h0002, w);
    checkOutput("rr_after_okay_gap", 32'(w), 32'd1);
    waitRelease("rr_second", 16'h0004, w);
    checkOutput("resv_timeout_gap", 32'(w), 32'd5);
    waitRelease("rr_third", 16'h0020, w);
    checkOutput("resv_timeout_gap2", 32'(w), 32'd5);
    repeat (6) stepIdle(1'b0);

    // Locked transfer waits out a busy resource and is never split
    access(4'd6, 1'b1, 1'b1);
    sampleAfterEdge();
    checkOutput("lock_ready_1", 32'(HREADYOUT), 32'd0);
    checkOutput("lock_resp",    32'(HRESP),     32'd0);
    stepIdle(1'b1);
    sampleAfterEdge();
    checkOutput("lock_ready_2", 32'(HREADYOUT), 32'd0);
    stepIdle(1'b1);
    sampleAfterEdge();
    checkOutput("lock_ready_3", 32'(HREADYOUT), 32'd0);
    stepIdle(1'b0);
    sampleAfterEdge();
    checkOutput("lock_done_ready", 32'(HREADYOUT), 32'd1);
    checkOutput("lock_done_start", 32'(ResStart),  32'd1);
    checkOutput("lock_pend",       32'(SplitPend), 32'h0000);
    repeat (2) stepIdle(1'b0);

    // Asynchronous reset in the middle of a SPLIT response
    access(4'd3, 1'b0, 1'b1);
    sampleAfterEdge();
    checkOutput("midrst_pre_ready", 32'(HREADYOUT), 32'd0);
    monitor_on = 1'b0;
    HRST_N     = 1'b0;
    #1;
    checkResetOutputs("midrst");
    exp_q.delete();
    HSEL    = 1'b0;
    ResBusy = 1'b0;
    repeat (2) @(posedge HCLK);
    @(negedge HCLK);
    modelReset();
    HRST_N     = 1'b1;
    monitor_on = 1'b1;

    // Randomized traffic
    busy_r = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(5) == 0) busy_r = !busy_r;
      applyStimulus(1'($urandom_range(1)), 2'($urandom_range(3)), 4'($urandom_range(15)),
                    ($urandom_range(9) == 0), busy_r, ($urandom_range(9) != 0));
    end
    sampleAfterEdge();
    checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
